// File: rtl/sram_slot_arbiter.sv
// sram_slot_arbiter
// Shares the single external 16-bit SRAM port between the video shifter,
// the CPU bus and the debug host. Video owns phase 0 of every 16-pixel group.
// CPU and host take turns for the other phases. Each access is one cycle and
// is followed by a one-cycle reply pulse to the requester that was granted.
module sram_slot_arbiter #(
  parameter int         ADDR_W   = 18,
  parameter int         DATA_W   = 16,
  parameter logic [4:0] VID_BASE = 5'b00001
) (
  input  logic              clk_cpu,
  input  logic              reset_in,
  input  logic [3:0]        slot_phase,
  input  logic [12:0]       vid_addr,
  output logic              vid_load,
  input  logic              cpu_rd,
  input  logic              cpu_wt,
  input  logic [ADDR_W-1:0] cpu_adr,
  input  logic              cpu_byte,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_reply,
  input  logic              host_rd,
  input  logic              host_wt,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_ack,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_dq_o,
  output logic              ram_dq_oe,
  input  logic [DATA_W-1:0] ram_dq_i,
  output logic              ram_oe_n,
  output logic              ram_we_n,
  output logic              ram_lb_n,
  output logic              ram_ub_n
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CPU_RD  = 3'd1,
    ST_CPU_WR  = 3'd2,
    ST_HOST_RD = 3'd3,
    ST_HOST_WR = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  state_t              state_r;
  state_t              state_s;
  logic                rr_host_r;
  logic                grant_cpu_s;
  logic                grant_host_s;
  logic                cpu_req_s;
  logic                host_req_s;
  logic                phase_ok_s;
  logic                wr_next_s;
  logic [ADDR_W-1:0]   cpu_word_s;
  logic                ram_we_n_r;
  logic                ram_dq_oe_r;
  logic [DATA_W-1:0]   ram_dq_o_r;
  logic                cpu_reply_r;
  logic                host_ack_r;
  logic [DATA_W-1:0]   cpu_rdata_r;
  logic [DATA_W-1:0]   host_rdata_r;

  // A grant at phase 14 or 15 would put the access on phase 15 or 0, so
  // those edges are skipped; the CPU bus carries byte addresses.
  assign cpu_req_s  = cpu_rd | cpu_wt;
  assign host_req_s = host_rd | host_wt;
  assign phase_ok_s = (slot_phase != 4'd14) && (slot_phase != 4'd15);
  assign cpu_word_s = {1'b0, cpu_adr[ADDR_W-1:1]};
  assign wr_next_s  = (state_s == ST_CPU_WR) || (state_s == ST_HOST_WR);

  // State register; reset drops any access in flight.
  always_ff @(posedge clk_cpu or posedge reset_in) begin
    if (reset_in) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode, arbitration and the combinational SRAM address/strobes.
  always_comb begin
    state_s      = state_r;
    grant_cpu_s  = 1'b0;
    grant_host_s = 1'b0;
    vid_load     = 1'b0;
    ram_addr     = {ADDR_W{1'b0}};
    ram_oe_n     = 1'b1;
    ram_lb_n     = 1'b0;
    ram_ub_n     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (phase_ok_s && host_req_s && (rr_host_r || !cpu_req_s)) begin
          grant_host_s = 1'b1;
          state_s      = host_rd ? ST_HOST_RD : ST_HOST_WR;
        end else if (phase_ok_s && cpu_req_s) begin
          grant_cpu_s = 1'b1;
          state_s     = cpu_rd ? ST_CPU_RD : ST_CPU_WR;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_CPU_RD, ST_CPU_WR: begin
        ram_addr = cpu_word_s;
        ram_oe_n = (state_r == ST_CPU_RD) ? 1'b0 : 1'b1;
        ram_lb_n = cpu_byte & cpu_adr[0];
        ram_ub_n = cpu_byte & ~cpu_adr[0];
        state_s  = ST_DONE;
      end
      ST_HOST_RD, ST_HOST_WR: begin
        ram_addr = host_addr;
        ram_oe_n = (state_r == ST_HOST_RD) ? 1'b0 : 1'b1;
        state_s  = ST_DONE;
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
    // Video fetch owns phase 0 regardless of the FSM.
    if (slot_phase == 4'd0) begin
      vid_load = 1'b1;
      ram_addr = {VID_BASE, vid_addr};
      ram_oe_n = 1'b0;
      ram_lb_n = 1'b0;
      ram_ub_n = 1'b0;
    end else begin
      vid_load = 1'b0;
    end
  end

  // Round-robin pointer: after a grant the other requester gets priority.
  always_ff @(posedge clk_cpu or posedge reset_in) begin
    if (reset_in) begin
      rr_host_r <= 1'b0;
    end else if (grant_cpu_s) begin
      rr_host_r <= 1'b1;
    end else if (grant_host_s) begin
      rr_host_r <= 1'b0;
    end else begin
      rr_host_r <= rr_host_r;
    end
  end

  // Write strobe and data drive are flops so they cannot glitch.
  always_ff @(posedge clk_cpu or posedge reset_in) begin
    if (reset_in) begin
      ram_we_n_r  <= 1'b1;
      ram_dq_oe_r <= 1'b0;
      ram_dq_o_r  <= {DATA_W{1'b0}};
    end else begin
      ram_we_n_r  <= ~wr_next_s;
      ram_dq_oe_r <= wr_next_s;
      if (state_s == ST_CPU_WR) begin
        ram_dq_o_r <= cpu_wdata;
      end else if (state_s == ST_HOST_WR) begin
        ram_dq_o_r <= host_wdata;
      end else begin
        ram_dq_o_r <= ram_dq_o_r;
      end
    end
  end

  // Reply pulses land in DONE; read data is captured at the end of the access.
  always_ff @(posedge clk_cpu or posedge reset_in) begin
    if (reset_in) begin
      cpu_reply_r  <= 1'b0;
      host_ack_r   <= 1'b0;
      cpu_rdata_r  <= {DATA_W{1'b0}};
      host_rdata_r <= {DATA_W{1'b0}};
    end else begin
      cpu_reply_r <= (state_r == ST_CPU_RD) || (state_r == ST_CPU_WR);
      host_ack_r  <= (state_r == ST_HOST_RD) || (state_r == ST_HOST_WR);
      if (state_r == ST_CPU_RD) begin
        cpu_rdata_r <= ram_dq_i;
      end else begin
        cpu_rdata_r <= cpu_rdata_r;
      end
      if (state_r == ST_HOST_RD) begin
        host_rdata_r <= ram_dq_i;
      end else begin
        host_rdata_r <= host_rdata_r;
      end
    end
  end

  assign ram_we_n   = ram_we_n_r;
  assign ram_dq_oe  = ram_dq_oe_r;
  assign ram_dq_o   = ram_dq_o_r;
  assign cpu_reply  = cpu_reply_r;
  assign host_ack   = host_ack_r;
  assign cpu_rdata  = cpu_rdata_r;
  assign host_rdata = host_rdata_r;

endmodule

// File: tb/tb_sram_slot_arbiter.sv
// Scoreboard bench for sram_slot_arbiter: stimulus pushes expected replies
// (read data and slot phase of the pulse); a monitor pops and compares.
module tb_sram_slot_arbiter;

  typedef struct {
    logic [15:0] rdata;
    logic [3:0]  phase;
  } exp_t;

  logic        clk_cpu;
  logic        reset_in;
  logic [3:0]  slot_phase;
  logic [12:0] vid_addr;
  logic        vid_load;
  logic        cpu_rd, cpu_wt, cpu_byte;
  logic [17:0] cpu_adr;
  logic [15:0] cpu_wdata, cpu_rdata;
  logic        cpu_reply;
  logic        host_rd, host_wt;
  logic [17:0] host_addr;
  logic [15:0] host_wdata, host_rdata;
  logic        host_ack;
  logic [17:0] ram_addr;
  logic [15:0] ram_dq_o, ram_dq_i;
  logic        ram_dq_oe, ram_oe_n, ram_we_n, ram_lb_n, ram_ub_n;
  logic        dq_fix_en;
  logic [15:0] dq_fix;

  exp_t cpu_q[$];
  exp_t host_q[$];
  int   tests_run    = 0;
  int   tests_failed = 0;

  sram_slot_arbiter dut (
    .clk_cpu(clk_cpu), .reset_in(reset_in), .slot_phase(slot_phase),
    .vid_addr(vid_addr), .vid_load(vid_load),
    .cpu_rd(cpu_rd), .cpu_wt(cpu_wt), .cpu_adr(cpu_adr), .cpu_byte(cpu_byte),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_reply(cpu_reply),
    .host_rd(host_rd), .host_wt(host_wt), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_rdata(host_rdata), .host_ack(host_ack),
    .ram_addr(ram_addr), .ram_dq_o(ram_dq_o), .ram_dq_oe(ram_dq_oe),
    .ram_dq_i(ram_dq_i), .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n),
    .ram_lb_n(ram_lb_n), .ram_ub_n(ram_ub_n)
  );

  // SRAM model: fixed word when forced, otherwise a pattern of the address.
  assign ram_dq_i = dq_fix_en ? dq_fix : (ram_addr[15:0] ^ 16'h5A5A);

  initial begin
    clk_cpu = 1'b0;
    forever #5 clk_cpu = ~clk_cpu;
  end

  // Pixel phase advances once per clock, just after the edge.
  initial begin
    slot_phase = 4'd0;
    forever begin
      @(posedge clk_cpu);
      #1 slot_phase = slot_phase + 4'd1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h (t=%0t phase=%0d)", name, act, exp, $time, slot_phase);
    end
  endtask

  task automatic wait_phase(input logic [3:0] p);
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk_cpu);
      if (slot_phase == p) seen = 1'b1;
    end
    if (!seen) begin
      tests_run++;
      tests_failed++;
      $display("FAIL phase_timeout: phase %0d never reached", p);
    end
  endtask

  task automatic wait_reply(input bit is_host);
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk_cpu);
      if (is_host ? host_ack : cpu_reply) seen = 1'b1;
    end
    if (!seen) begin
      tests_run++;
      tests_failed++;
      $display("FAIL reply_timeout: %s reply never seen", is_host ? "host" : "cpu");
    end
  endtask

  // Monitor: pops expectations on every reply pulse and checks video slots.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_cpu);
      if (cpu_reply || host_ack)
        check("single_reply", {31'd0, cpu_reply & host_ack}, 32'd0);
      if (cpu_reply) begin
        if (cpu_q.size() == 0) begin
          check("cpu_unexpected_reply", {31'd0, cpu_reply}, 32'd0);
        end else begin
          e = cpu_q.pop_front();
          check("cpu_rdata", {16'd0, cpu_rdata}, {16'd0, e.rdata});
          check("cpu_reply_phase", {28'd0, slot_phase}, {28'd0, e.phase});
        end
      end
      if (host_ack) begin
        if (host_q.size() == 0) begin
          check("host_unexpected_ack", {31'd0, host_ack}, 32'd0);
        end else begin
          e = host_q.pop_front();
          check("host_rdata", {16'd0, host_rdata}, {16'd0, e.rdata});
          check("host_ack_phase", {28'd0, slot_phase}, {28'd0, e.phase});
        end
      end
      if (slot_phase == 4'd0) begin
        check("vid_load", {31'd0, vid_load}, 32'd1);
        check("vid_addr", {14'd0, ram_addr}, {14'd0, 5'b00001, vid_addr});
        check("vid_oe_n", {31'd0, ram_oe_n}, 32'd0);
      end else if (vid_load) begin
        check("vid_load_off_phase", {31'd0, vid_load}, 32'd0);
      end
    end
  end

  function automatic exp_t mk(input logic [15:0] d, input logic [3:0] p);
    exp_t e;
    e.rdata = d;
    e.phase = p;
    return e;
  endfunction

  initial begin
    reset_in = 1'b1; vid_addr = 13'h1ABC;
    cpu_rd = 1'b0; cpu_wt = 1'b0; cpu_byte = 1'b0; cpu_adr = 18'h0; cpu_wdata = 16'h0;
    host_rd = 1'b0; host_wt = 1'b0; host_addr = 18'h0; host_wdata = 16'h0;
    dq_fix_en = 1'b0; dq_fix = 16'h0;

    // Reset values (checked away from phase 0, where video owns the strobes)
    repeat (3) @(negedge clk_cpu);
    check("rst_oe_n", {31'd0, ram_oe_n}, 32'd1);
    check("rst_we_n", {31'd0, ram_we_n}, 32'd1);
    check("rst_dq_oe", {31'd0, ram_dq_oe}, 32'd0);
    check("rst_cpu_reply", {31'd0, cpu_reply}, 32'd0);
    check("rst_host_ack", {31'd0, host_ack}, 32'd0);
    check("rst_cpu_rdata", {16'd0, cpu_rdata}, 32'd0);
    check("rst_host_rdata", {16'd0, host_rdata}, 32'd0);
    reset_in = 1'b0;

    // Round-robin: both read together twice; CPU then host each round
    wait_phase(4'd2);
    cpu_rd = 1'b1; cpu_adr = 18'h00400; host_rd = 1'b1; host_addr = 18'h00300;
    cpu_q.push_back(mk(16'h585A, 4'd4));
    host_q.push_back(mk(16'h595A, 4'd7));
    wait_reply(1'b0); cpu_rd = 1'b0;
    wait_reply(1'b1); host_rd = 1'b0;
    wait_phase(4'd9);
    cpu_rd = 1'b1; cpu_adr = 18'h00800; host_rd = 1'b1; host_addr = 18'h00123;
    cpu_q.push_back(mk(16'h5E5A, 4'd11));
    host_q.push_back(mk(16'h5B79, 4'd14));
    wait_reply(1'b0); cpu_rd = 1'b0;
    wait_reply(1'b1); host_rd = 1'b0;

    // Read pending at phase 15: skipped past 15 and video phase 0
    wait_phase(4'd15);
    cpu_rd = 1'b1; cpu_adr = 18'h00010;
    cpu_q.push_back(mk(16'h5A52, 4'd2));
    wait_reply(1'b0); cpu_rd = 1'b0;

    // Word read with fixed SRAM data
    wait_phase(4'd3);
    vid_addr = 13'h0123; dq_fix_en = 1'b1; dq_fix = 16'hA5A5;
    cpu_rd = 1'b1; cpu_adr = 18'h02000;
    cpu_q.push_back(mk(16'hA5A5, 4'd5));
    @(negedge clk_cpu);
    check("rd_addr", {14'd0, ram_addr}, {14'd0, 18'h01000});
    check("rd_oe_n", {31'd0, ram_oe_n}, 32'd0);
    check("rd_we_n", {31'd0, ram_we_n}, 32'd1);
    wait_reply(1'b0); cpu_rd = 1'b0; dq_fix_en = 1'b0;

    // Byte write at an odd address: only the high lane enabled
    wait_phase(4'd6);
    cpu_wt = 1'b1; cpu_byte = 1'b1; cpu_adr = 18'h00101; cpu_wdata = 16'h3400;
    cpu_q.push_back(mk(16'hA5A5, 4'd8));
    @(negedge clk_cpu);
    check("bw_we_n", {31'd0, ram_we_n}, 32'd0);
    check("bw_dq_oe", {31'd0, ram_dq_oe}, 32'd1);
    check("bw_oe_n", {31'd0, ram_oe_n}, 32'd1);
    check("bw_dq_o", {16'd0, ram_dq_o}, {16'd0, 16'h3400});
    check("bw_addr", {14'd0, ram_addr}, {14'd0, 18'h00080});
    check("bw_lb_n", {31'd0, ram_lb_n}, 32'd1);
    check("bw_ub_n", {31'd0, ram_ub_n}, 32'd0);
    wait_reply(1'b0);
    check("bw_we_n_release", {31'd0, ram_we_n}, 32'd1);
    check("bw_dq_oe_release", {31'd0, ram_dq_oe}, 32'd0);
    cpu_wt = 1'b0; cpu_byte = 1'b0;

    // Host write requested at phase 14 lands on phase 1
    wait_phase(4'd14);
    vid_addr = 13'h1FFF;
    host_wt = 1'b1; host_addr = 18'h3FFFF; host_wdata = 16'hBEEF;
    host_q.push_back(mk(16'h5B79, 4'd2));
    @(negedge clk_cpu);
    check("p15_no_access", {31'd0, ram_we_n}, 32'd1);
    @(negedge clk_cpu);
    check("p0_no_access", {31'd0, ram_we_n}, 32'd1);
    @(negedge clk_cpu);
    check("hw_phase", {28'd0, slot_phase}, 32'd1);
    check("hw_we_n", {31'd0, ram_we_n}, 32'd0);
    check("hw_addr", {14'd0, ram_addr}, {14'd0, 18'h3FFFF});
    check("hw_dq_o", {16'd0, ram_dq_o}, {16'd0, 16'hBEEF});
    check("hw_lanes", {30'd0, ram_lb_n, ram_ub_n}, 32'd0);
    wait_reply(1'b1); host_wt = 1'b0;

    // Reset in the middle of a CPU write
    wait_phase(4'd4);
    cpu_wt = 1'b1; cpu_adr = 18'h00200; cpu_wdata = 16'h1111;
    @(negedge clk_cpu);
    check("mid_we_n_before", {31'd0, ram_we_n}, 32'd0);
    reset_in = 1'b1;
    #1;
    check("mid_rst_we_n", {31'd0, ram_we_n}, 32'd1);
    check("mid_rst_dq_oe", {31'd0, ram_dq_oe}, 32'd0);
    check("mid_rst_oe_n", {31'd0, ram_oe_n}, 32'd1);
    cpu_wt = 1'b0;
    repeat (2) begin
      @(negedge clk_cpu);
      check("mid_rst_no_reply", {31'd0, cpu_reply}, 32'd0);
    end
    check("mid_rst_cpu_rdata", {16'd0, cpu_rdata}, 32'd0);
    check("mid_rst_host_rdata", {16'd0, host_rdata}, 32'd0);
    reset_in = 1'b0;

    // After reset: IDLE with rr_host cleared, so CPU wins a tie
    wait_phase(4'd8);
    cpu_rd = 1'b1; cpu_adr = 18'h00010; host_rd = 1'b1; host_addr = 18'h00300;
    cpu_q.push_back(mk(16'h5A52, 4'd10));
    host_q.push_back(mk(16'h595A, 4'd13));
    wait_reply(1'b0); cpu_rd = 1'b0;
    wait_reply(1'b1); host_rd = 1'b0;

    for (int i = 0; i < 20 && (cpu_q.size() != 0 || host_q.size() != 0); i++)
      @(negedge clk_cpu);
    repeat (4) @(negedge clk_cpu);
    check("cpu_q_drained", cpu_q.size(), 32'd0);
    check("host_q_drained", host_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
